// File: rtl/serial_alu_if.sv
// Serial ALU port bundle: the operand/opcode stream in, the result stream and flags out.
// Handshake: start is taken only while busy=0; bits 1..XLEN-1 follow on consecutive clocks with no stall.
interface serial_alu_if;
  logic       start;
  logic [2:0] op;
  logic       a_bit;
  logic       b_bit;
  logic       busy;
  logic       res_bit;
  logic       res_valid;
  logic       slt;
  logic       done;
  logic       run_dbg;

  modport master (
    output start, op, a_bit, b_bit,
    input  busy, res_bit, res_valid, slt, done, run_dbg
  );

  modport slave (
    input  start, op, a_bit, b_bit,
    output busy, res_bit, res_valid, slt, done, run_dbg
  );
endinterface

// File: rtl/serial_alu.sv
// Bit-serial ALU: one operand bit per clock, LSB first, registered result stream,
// set-less-than flag produced at the MSB of subtract-type passes.
module serial_alu #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  serial_alu_if.slave  bus
);

  localparam int IW = (XLEN > 2) ? $clog2(XLEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(XLEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic [2:0]    op_q;
  logic          carry_q;
  logic          res_q, valid_q, done_q, slt_q;

  logic       accept, is_last, active, sub_op;
  logic [2:0] cur_op;
  logic       b_eff, cin, sum, cout, r_bit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    is_last  = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept   = 1'b1;
        state_nx = RUN;
      end
      RUN: if (idx == LAST) begin
        is_last  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bit 0 is processed in the accept cycle, so the opcode and carry-in come
  // straight from the inputs there rather than from the latched copies.
  always_comb begin
    cur_op = accept ? bus.op : op_q;
    active = accept || (state == RUN);
    sub_op = (cur_op == 3'b001) || (cur_op == 3'b010) || (cur_op == 3'b011);
    b_eff  = bus.b_bit ^ sub_op;
    cin    = accept ? sub_op : carry_q;
    sum    = bus.a_bit ^ b_eff ^ cin;
    cout   = (bus.a_bit & b_eff) | (bus.a_bit & cin) | (b_eff & cin);
    case (cur_op)
      3'b000, 3'b001, 3'b010, 3'b011: r_bit = sum;
      3'b100:  r_bit = bus.a_bit ^ bus.b_bit;
      3'b110:  r_bit = bus.a_bit | bus.b_bit;
      3'b111:  r_bit = bus.a_bit & bus.b_bit;
      default: r_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      op_q    <= 3'b000;
      carry_q <= 1'b0;
      res_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      slt_q   <= 1'b0;
    end else begin
      valid_q <= active;
      res_q   <= active & r_bit;
      done_q  <= is_last;
      if (active) carry_q <= cout;
      if (accept) begin
        op_q <= bus.op;
        idx  <= IW'(1);
      end else if (state == RUN) begin
        idx <= is_last ? '0 : idx + IW'(1);
      end
      // Signed compare: differing signs decide directly, otherwise the difference sign does.
      if (is_last) begin
        case (op_q)
          3'b001, 3'b010: slt_q <= (bus.a_bit != bus.b_bit) ? bus.a_bit : sum;
          3'b011:         slt_q <= ~cout;
          default:        slt_q <= slt_q;
        endcase
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.run_dbg   = (state == RUN);
  assign bus.res_bit   = res_q;
  assign bus.res_valid = valid_q;
  assign bus.done      = done_q;
  assign bus.slt       = slt_q;

endmodule

// File: doc/serial_alu.md
# serial_alu

Bit-serial integer ALU for the single-bit datapath core. It consumes two operands one bit per clock, LSB first, and produces a registered result bit stream in the same order. At the end of each pass it produces a set-less-than flag. It sits directly upstream of the branch unit: `res_bit` feeds the branch unit's serial "ALU output" input (OR-accumulated for BEQ/BNE), and `slt` feeds its compare input (BLT/BGE/BLTU/BGEU). Shifts are handled by a separate shifter, not here.

## Interface
- `XLEN`, default 32: operand width and pass length in clocks; ≥ 2.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: begin a pass; sampled only when `busy`=0; carries bit 0 of both operands.
- `op`  in  3: 000 ADD, 001 SUB, 010 SLT, 011 SLTU, 100 XOR, 101 reserved, 110 OR, 111 AND; latched on accepted `start`.
- `a_bit`  in  1: operand A serial bit, LSB first.
- `b_bit`  in  1: operand B serial bit, LSB first.
- `busy`  out  1: pass in progress (bits 1..XLEN-1 being sampled).
- `res_bit`  out  1: registered result bit.
- `res_valid`  out  1: `res_bit` is valid this cycle.
- `slt`  out  1: comparison result of the last SLT/SLTU/SUB pass; held until the next pass ends.
- `done`  out  1: one-cycle pulse coincident with the MSB on `res_bit`.

## Operation
- Two states, IDLE and RUN, plus a bit counter `idx` of width clog2(XLEN).
- IDLE + `start`:
  - latch `op`, set `idx`=1, go to RUN;
  - process bit 0 in the same cycle;
  - carry-in is 1 for SUB/SLT/SLTU, else 0.
- RUN: process one bit per cycle and increment `idx`. After the bit with `idx`=XLEN-1 is processed, return to IDLE.
- Subtract ops (SUB, SLT, SLTU):
  - compute A + ~B + carry;
  - `res_bit` = difference bit; the carry register updates every bit;
  - SLT and SLTU also stream the difference bits, which lets the branch unit detect inequality on any compare op;
  - the writeback path uses `slt`, not the stream, for SLT/SLTU rd.
- ADD: sum bit with a ripple carry register.
- XOR/OR/AND: bitwise; the carry register is unused.
- Reserved op 101: `res_bit`=0 for the whole pass; `slt` is unchanged.
- `slt` is updated at the MSB of subtract ops only:
  - signed: `slt` = (a_msb≠b_msb) ? a_msb : diff_msb;
  - unsigned: `slt` = NOT carry-out of the MSB add;
  - SUB updates `slt` with the signed rule;
  - ADD/logic passes leave `slt` unchanged.
- `start` while `busy`=1 is ignored, with no effect on the current pass.
- Arithmetic is modulo 2^XLEN; carry-out is discarded except for SLTU.

## Timing
- Edge E0 samples `start` and bit 0. Edge Ei samples bit i.
- `res_bit`/`res_valid` for bit i are valid in the cycle after Ei.
- Latency is 1 clock per bit. `res_valid` is high for exactly XLEN consecutive cycles.
- `busy`=1 from after E0 through E(XLEN-1); it is low in the cycle following E(XLEN-1).
- `done`=1 and the new `slt` value appear in that same cycle, together with the MSB on `res_bit`.
- Back-to-back: `start` may be asserted in the `done` cycle. Throughput is one op per XLEN clocks, with no bubble.
- Reset values:
  - `busy`=0, `res_bit`=0, `res_valid`=0, `done`=0, `slt`=0;
  - carry=0, `idx`=0, state IDLE.
- `rst` mid-pass aborts the pass: no `done`, `slt` cleared, `res_valid` low from the next cycle.
- `rst` and `start` in the same cycle: reset wins and `start` is dropped.

## Test plan
- ADD 5+3 (XLEN=32) → stream decodes to 0x00000008, `done` on the 32nd `res_valid` cycle, `slt` unchanged.
- SUB 0x1234 − 0x1234 → all 32 result bits 0, `slt`=0. SUB 3 − 5 → 0xFFFFFFFE, `slt`=1.
- Compare pairs:
  - SLT 0xFFFFFFFF vs 1 → `slt`=1;
  - SLTU 0xFFFFFFFF vs 1 → `slt`=0;
  - SLT 0x7FFFFFFF vs 0x80000000 → `slt`=0;
  - SLTU 0x7FFFFFFF vs 0x80000000 → `slt`=1.
- AND/OR/XOR of 0xF0F0A5A5 and 0x0FF05A5A → 0x00F00000 / 0xFFF0FFFF / 0xFF00FFFF. Op 101 → all zeros.
- Back-to-back ADD then SLT with `start` in the `done` cycle → no gap in `res_valid`, both results correct. A `start` pulse mid-pass → ignored, result unaffected.
- `rst` at bit 10 of a SUB pass → no `done`, all outputs 0 next cycle. A following ADD 1+1 → 0x00000002.
